wr_ctrl_1ch: RTL

//   Ingress write controller for one switch port. Accepts a packet stream, takes one packet-buffer base address

---
 rtl/wr_ctrl_pkg.sv | 41 ++++
 rtl/wr_ctrl_1ch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wr_ctrl_pkg.sv
// Shared types and constants for the single-channel ingress write controller.
//   wr_state_e : controller FSM states
//   DEST_LSB/PRI_LSB : header field positions inside the first packet word
//   wr_tag_t   : layout of the tag handed to the output priority queues
//   sat_inc16  : saturating increment used by the drop counter
package wr_ctrl_pkg;

    localparam int WR_DATA_W    = 64;
    localparam int WR_ADDR_W    = 11;
    localparam int WR_MAX_WORDS = 32;
    localparam int WR_LEN_W     = $clog2(WR_MAX_WORDS) + 1;

    localparam int DEST_LSB = 0;
    localparam int DEST_W   = 4;
    localparam int PRI_LSB  = 4;
    localparam int PRI_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2,
        TAG  = 2'd3
    } wr_state_e;

    // Field order matches oTagData, MSB first.
    typedef struct packed {
        logic [WR_LEN_W-1:0]  len;
        logic [WR_ADDR_W-1:0] base;
        logic [PRI_W-1:0]     pri;
        logic [DEST_W-1:0]    dest;
    } wr_tag_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/wr_ctrl_1ch.sv
// Ingress write controller for one switch port.
// Pops one buffer base from the free list, writes each packet word to shared
// SRAM at base|offset and, at end of packet, presents one tag
// {len,base,pri,dest}. Oversized packets and framing errors are counted.
// Ports:
//   iClk, iRst_n                     clock, async active-low reset
//   iWrSop/iWrEop/iWrVld/iWrData     ingress word stream, oWrRdy ready
//   iFreeVld/iFreeAddr, oFreeRdy     free-list base address pop
//   oMemWe/oMemAddr/oMemData         registered SRAM write port
//   oTagVld/oTagData, iTagRdy        tag toward the priority queues
//   oDropCnt                         saturating dropped-packet counter
module wr_ctrl_1ch
    import wr_ctrl_pkg::*;
#(
    parameter int DATA_W    = WR_DATA_W,
    parameter int ADDR_W    = WR_ADDR_W,
    parameter int MAX_WORDS = WR_MAX_WORDS,
    localparam int LEN_W    = $clog2(MAX_WORDS) + 1
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic                      iWrSop,
    input  logic                      iWrEop,
    input  logic                      iWrVld,
    input  logic [DATA_W-1:0]         iWrData,
    output logic                      oWrRdy,
    input  logic                      iFreeVld,
    input  logic [ADDR_W-1:0]         iFreeAddr,
    output logic                      oFreeRdy,
    output logic                      oMemWe,
    output logic [ADDR_W-1:0]         oMemAddr,
    output logic [DATA_W-1:0]         oMemData,
    output logic                      oTagVld,
    output logic [7+ADDR_W+LEN_W-1:0] oTagData,
    input  logic                      iTagRdy,
    output logic [15:0]               oDropCnt
);

    localparam int CNT_W = LEN_W - 1;

    wr_state_e             state_q, state_d;
    logic                  addr_held_q, addr_held_d;
    logic                  free_rdy_q, free_rdy_d;
    logic                  wr_rdy_q, wr_rdy_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEST_W-1:0]     dest_q, dest_d;
    logic [PRI_W-1:0]      pri_q, pri_d;
    logic [LEN_W-1:0]      tag_len_q, tag_len_d;
    logic                  tag_vld_q, tag_vld_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_data_q, mem_data_d;

    logic                  wr_fire_s;
    logic                  free_fire_s;

    assign wr_fire_s   = iWrVld & wr_rdy_q;
    assign free_fire_s = iFreeVld & free_rdy_q;

    // Next-state, SRAM write and tag decisions for the current word.
    always_comb begin
        state_d     = state_q;
        addr_held_d = addr_held_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        dest_d      = dest_q;
        pri_d       = pri_q;
        tag_len_d   = tag_len_q;
        tag_vld_d   = tag_vld_q;
        drop_cnt_d  = drop_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;

        // Prefetch: a base is popped whenever none is held, independent of the FSM.
        if (free_fire_s) begin
            base_d      = iFreeAddr;
            addr_held_d = 1'b1;
        end else begin
            base_d      = base_q;
        end

        case (state_q)
            IDLE: begin
                if (wr_fire_s && iWrSop) begin
                    dest_d     = iWrData[DEST_LSB +: DEST_W];
                    pri_d      = iWrData[PRI_LSB +: PRI_W];
                    mem_we_d   = 1'b1;
                    mem_addr_d = base_q;
                    mem_data_d = iWrData;
                    cnt_d      = CNT_W'(1);
                    if (iWrEop) begin
                        tag_len_d = LEN_W'(1);
                        tag_vld_d = 1'b1;
                        state_d   = TAG;
                    end else begin
                        state_d   = DATA;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (wr_fire_s && iWrSop) begin
                    // Framing error: abandon the old packet, restart in the same slot.
                    drop_cnt_d = sat_inc16(drop_cnt_q);
                    dest_d     = iWrData[DEST_LSB +: DEST_W];
                    pri_d      = iWrData[PRI_LSB +: PRI_W];
                    mem_we_d   = 1'b1;
                    mem_addr_d = base_q;
                    mem_data_d = iWrData;
                    cnt_d      = CNT_W'(1);
                    if (iWrEop) begin
                        tag_len_d = LEN_W'(1);
                        tag_vld_d = 1'b1;
                        state_d   = TAG;
                    end else begin
                        state_d   = DATA;
                    end
                end else if (wr_fire_s) begin
                    mem_we_d   = 1'b1;
                    // Base is slot-aligned, so OR places the offset without a carry.
                    mem_addr_d = base_q | ADDR_W'(cnt_q);
                    mem_data_d = iWrData;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (iWrEop) begin
                        tag_len_d = {1'b0, cnt_q} + LEN_W'(1);
                        tag_vld_d = 1'b1;
                        state_d   = TAG;
                    end else if (cnt_q == CNT_W'(MAX_WORDS - 1)) begin
                        state_d   = DROP;
                    end else begin
                        state_d   = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            DROP: begin
                // Slot stays held; the next packet overwrites it.
                if (wr_fire_s && iWrEop) begin
                    drop_cnt_d = sat_inc16(drop_cnt_q);
                    state_d    = IDLE;
                end else begin
                    state_d    = DROP;
                end
            end
            TAG: begin
                if (iTagRdy) begin
                    tag_vld_d   = 1'b0;
                    addr_held_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = TAG;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready outputs are registered from the next-cycle state.
    always_comb begin
        free_rdy_d = ~addr_held_d;
        case (state_d)
            IDLE:    wr_rdy_d = addr_held_d;
            DATA:    wr_rdy_d = 1'b1;
            DROP:    wr_rdy_d = 1'b1;
            TAG:     wr_rdy_d = 1'b0;
            default: wr_rdy_d = 1'b0;
        endcase
    end

    // State, slot bookkeeping and registered output pipeline.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= IDLE;
            addr_held_q <= 1'b0;
            free_rdy_q  <= 1'b0;
            wr_rdy_q    <= 1'b0;
            base_q      <= '0;
            cnt_q       <= '0;
            dest_q      <= '0;
            pri_q       <= '0;
            tag_len_q   <= '0;
            tag_vld_q   <= 1'b0;
            drop_cnt_q  <= 16'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_held_q <= addr_held_d;
            free_rdy_q  <= free_rdy_d;
            wr_rdy_q    <= wr_rdy_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            dest_q      <= dest_d;
            pri_q       <= pri_d;
            tag_len_q   <= tag_len_d;
            tag_vld_q   <= tag_vld_d;
            drop_cnt_q  <= drop_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign oWrRdy   = wr_rdy_q;
    assign oFreeRdy = free_rdy_q;
    assign oMemWe   = mem_we_q;
    assign oMemAddr = mem_addr_q;
    assign oMemData = mem_data_q;
    assign oTagVld  = tag_vld_q;
    // base is held until the tag handshake, so the tag is stable while valid.
    assign oTagData = {tag_len_q, base_q, pri_q, dest_q};
    assign oDropCnt = drop_cnt_q;

endmodule
